wm_phase_timer: RTL and testbench

- Phase timer and scheduler for the washing-machine controller FSM.
- Consumes the FSM's timer_enable and phase_sel, then selects a per-mode, per-phase duration and counts it down on a prescaled 1 s tick.
- Returns a one-cycle timer_done pulse that advances the FSM to the next phase.
- Freezes the countdown while the lid is open, and exposes remaining time for display.

---
 rtl/wm_phase_timer_pkg.sv | 51 +++++
 rtl/wm_phase_timer_if.sv | 23 ++
 rtl/wm_phase_timer_tick_prescaler.sv | 30 +++
 rtl/wm_phase_timer.sv | 106 ++++++++++
 tb/tb_wm_phase_timer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wm_phase_timer_pkg.sv
// Shared washing-machine definitions: phase codes, wash modes, timer states
// and the per-mode, per-phase duration table.
package wm_pkg;

  localparam logic [1:0] PH_SOAK  = 2'b00;
  localparam logic [1:0] PH_WASH  = 2'b01;
  localparam logic [1:0] PH_RINSE = 2'b10;
  localparam logic [1:0] PH_SPIN  = 2'b11;

  typedef enum logic [1:0] {
    QUICK  = 2'd0,
    NORMAL = 2'd1,
    HEAVY  = 2'd2
  } wm_mode_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // modes = {mode3, mode2, mode1}; heavier modes win, nothing selected means quick
  function automatic wm_mode_e wm_decode_mode(input logic [2:0] modes);
    wm_mode_e m;
    casez (modes)
      3'b1??:  m = HEAVY;
      3'b01?:  m = NORMAL;
      default: m = QUICK;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] wm_duration(input wm_mode_e mode, input logic [1:0] ph);
    logic [7:0] d;
    d = 8'd5;
    case (mode)
      QUICK:  d = (ph == PH_WASH) ? 8'd10 : 8'd5;
      NORMAL: d = (ph == PH_WASH) ? 8'd20 : 8'd10;
      HEAVY: begin
        case (ph)
          PH_SOAK:  d = 8'd20;
          PH_WASH:  d = 8'd40;
          PH_RINSE: d = 8'd20;
          default:  d = 8'd15;
        endcase
      end
      default: d = 8'd5;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wm_phase_timer_if.sv
// Controller-FSM <-> phase timer signal bundle.
interface wm_phase_timer_if #(parameter int CNT_W = 8);
  logic             timer_enable;
  logic [1:0]       phase_sel;
  logic             mode1;
  logic             mode2;
  logic             mode3;
  logic             lid;
  logic             timer_done;
  logic [CNT_W-1:0] remaining;
  logic             running;
  logic             paused;

  modport master (
    output timer_enable, phase_sel, mode1, mode2, mode3, lid,
    input  timer_done, remaining, running, paused
  );

  modport slave (
    input  timer_enable, phase_sel, mode1, mode2, mode3, lid,
    output timer_done, remaining, running, paused
  );
endinterface

// File: rtl/wm_phase_timer_tick_prescaler.sv
// Free-running divider: tick on every TICK_DIV-th cycle that is not held.
module wm_tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  // A held cycle never ticks, so a tick landing on a pause is deferred rather than lost
  assign tick = !hold && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer: loads a per-mode/per-phase duration and counts it down in
// prescaled time units, freezing while the lid is open.
//
// state | meaning
// IDLE  | not timing, remaining = 0
// RUN   | counting down
// PAUSE | lid open, prescaler and remaining frozen
// DONE  | duration expired, waiting for the FSM to move on
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  wm_phase_timer_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             running_q, paused_q;
  logic             clr, hold, tick;
  logic             load;
  logic [CNT_W-1:0] load_val;

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .hold  (hold),
    .tick  (tick)
  );

  // Mode is only sampled here, so mid-phase mode changes take effect at the next load
  assign load_val = CNT_W'(wm_duration(wm_decode_mode({bus.mode3, bus.mode2, bus.mode1}),
                                       bus.phase_sel));
  assign load     = bus.timer_enable && ((state_q == ST_IDLE) || (bus.phase_sel != ph_q));

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    hold    = 1'b1;
    if (!bus.timer_enable) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      clr     = 1'b1;
    end else if (load) begin
      ph_d  = bus.phase_sel;
      rem_d = load_val;
      clr   = 1'b1;
      if (load_val == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) || (state_q == ST_PAUSE)) begin
      // A closing lid lets the prescaler advance on that same cycle, so no time is lost
      hold = bus.lid;
      if (bus.lid) begin
        state_d = ST_PAUSE;
      end else if (tick) begin
        if (rem_q <= CNT_W'(1)) begin
          rem_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = ST_RUN;
        end
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ph_q      <= PH_SOAK;
      rem_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      paused_q  <= (state_d == ST_PAUSE);
    end
  end

  assign bus.timer_done = done_q;
  assign bus.remaining  = rem_q;
  assign bus.running    = running_q;
  assign bus.paused     = paused_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed plus randomized bench for wm_phase_timer against an elapsed-work model.
module tb_wm_phase_timer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wm_phase_timer_if #(.CNT_W(8)) bus();

  wm_phase_timer #(.TICK_DIV(TD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Model: 0 = idle, 1 = timing a phase, 2 = phase finished
  int m_st = 0;
  int m_ph = 0;
  int m_dur = 0;
  int m_worked = 0;
  bit m_done = 1'b0;
  bit m_paused = 1'b0;
  int tbl [3][4] = '{'{5, 10, 5, 5}, '{10, 20, 10, 10}, '{20, 40, 20, 15}};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_mode();
    if (bus.mode3) return 2;
    if (bus.mode2) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_ph = 0; m_dur = 0; m_worked = 0; m_done = 1'b0; m_paused = 1'b0;
  endfunction

  // Remaining = full duration minus whole time units of unpaused cycles spent
  function automatic int model_rem();
    return (m_st == 1) ? (m_dur - m_worked / TD) : 0;
  endfunction

  function automatic void model_edge();
    m_done = 1'b0;
    if (!bus.timer_enable) begin
      m_st = 0; m_worked = 0; m_paused = 1'b0;
    end else if (m_st == 0 || int'(bus.phase_sel) != m_ph) begin
      m_ph = int'(bus.phase_sel);
      m_dur = tbl[exp_mode()][m_ph];
      m_worked = 0;
      m_paused = 1'b0;
      m_st = (m_dur == 0) ? 2 : 1;
      m_done = (m_dur == 0);
    end else if (m_st == 1) begin
      if (bus.lid) begin
        m_paused = 1'b1;
      end else begin
        m_paused = 1'b0;
        m_worked++;
        if (m_worked == m_dur * TD) begin
          m_st = 2;
          m_done = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.timer_done) done_cnt++;
    check("timer_done", int'(bus.timer_done), int'(m_done));
    check("remaining", int'(bus.remaining), model_rem());
    check("running", int'(bus.running), int'(m_st == 1 && !m_paused));
    check("paused", int'(bus.paused), int'(m_st == 1 && m_paused));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.timer_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_mode(input bit m1, input bit m2, input bit m3);
    bus.mode1 = m1; bus.mode2 = m2; bus.mode3 = m3;
  endtask

  int n;
  int d0;

  initial begin
    bus.timer_enable = 1'b0;
    bus.phase_sel = 2'b00;
    set_mode(0, 0, 0);
    bus.lid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", int'(bus.timer_done), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_running", int'(bus.running), 0);
    check("rst_paused", int'(bus.paused), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal soak: 10 units, done after 40 cycles, single pulse
    set_mode(0, 1, 0);
    bus.phase_sel = 2'b00;
    bus.timer_enable = 1'b1;
    step();
    check("load_normal_soak", int'(bus.remaining), 10);
    done_cnt = 0;
    run_until_done(100, n);
    check("soak_done_latency", n, 40);
    steps(5);
    check("soak_single_pulse", done_cnt, 1);
    check("soak_done_remaining", int'(bus.remaining), 0);
    check("soak_done_not_running", int'(bus.running), 0);

    // Chain into wash without a second soak pulse
    bus.phase_sel = 2'b01;
    step();
    check("chain_reload_wash", int'(bus.remaining), 20);
    check("chain_no_done", int'(bus.timer_done), 0);
    check("chain_pulses", done_cnt, 1);

    // Cancel mid-wash
    steps(10);
    done_cnt = 0;
    bus.timer_enable = 1'b0;
    step();
    check("cancel_remaining", int'(bus.remaining), 0);
    check("cancel_running", int'(bus.running), 0);
    steps(3);
    check("cancel_no_done", done_cnt, 0);

    // Mode priority
    set_mode(1, 0, 1);
    bus.phase_sel = 2'b01;
    bus.timer_enable = 1'b1;
    step();
    check("prio_heavy_wash", int'(bus.remaining), 40);
    bus.timer_enable = 1'b0;
    step();
    set_mode(0, 0, 0);
    bus.phase_sel = 2'b11;
    bus.timer_enable = 1'b1;
    step();
    check("prio_none_spin", int'(bus.remaining), 5);
    set_mode(1, 1, 1);
    steps(3);
    check("mode_change_ignored", int'(bus.remaining), 5);
    bus.timer_enable = 1'b0;
    step();

    // Lid pause during heavy rinse
    set_mode(0, 0, 1);
    bus.phase_sel = 2'b10;
    bus.timer_enable = 1'b1;
    step();
    check("lid_load", int'(bus.remaining), 20);
    steps(2 * TD);
    bus.lid = 1'b1;
    steps(7);
    check("lid_hold_remaining", int'(bus.remaining), 18);
    check("lid_paused", int'(bus.paused), 1);
    bus.lid = 1'b0;
    run_until_done(200, n);
    check("lid_done_latency", (n < 0) ? n : n + 2 * TD + 7, 20 * TD + 7);
    bus.timer_enable = 1'b0;
    step();

    // Async reset mid-run, then full-duration restart
    set_mode(0, 1, 0);
    bus.phase_sel = 2'b01;
    bus.timer_enable = 1'b1;
    step();
    steps(15);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_remaining", int'(bus.remaining), 0);
    check("areset_running", int'(bus.running), 0);
    check("areset_done", int'(bus.timer_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("areset_reload", int'(bus.remaining), 20);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.timer_enable = ($urandom_range(99) < 97);
      bus.lid = ($urandom_range(99) < 8);
      if ($urandom_range(99) < 3) bus.phase_sel = 2'($urandom_range(3));
      if ($urandom_range(99) < 10) begin
        d0 = $urandom_range(7);
        set_mode(d0[0], d0[1], d0[2]);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
